apb_err_mon: RTL and testbench



---
 rtl/apb_err_mon.sv | 187 ++++++++++++++++++
 tb/tb_apb_err_mon.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_err_mon.sv
// apb_err_mon: registered APB error monitor.
// Decodes each APB transfer against NUM_REGIONS address windows. It flags
// out-of-range, misaligned and write-to-read-only accesses. It answers the
// access phase with pready/pslverr, and keeps a sticky status, a saturating
// error count and a one-cycle error interrupt.
// Optional first-error capture ports are built when APB_ERR_MON_CAPTURE_EN is defined.
module apb_err_mon #(
    parameter int unsigned                   ADDR_W        = 32,
    parameter int unsigned                   DATA_W        = 64,
    parameter int unsigned                   NUM_REGIONS   = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE   = {32'h0010_0000, 32'h0000_0000},
    parameter logic [NUM_REGIONS*8-1:0]      REGION_LOG2SZ = {8'd12, 8'd16},
    parameter logic [NUM_REGIONS-1:0]        REGION_RO     = 2'b10,
    parameter int unsigned                   CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    output logic              pready,
    output logic              pslverr,
    input  logic              clr,
    output logic [2:0]        err_status,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_irq
`ifdef APB_ERR_MON_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] err_addr,
    output logic [2:0]        err_type,
    output logic              err_valid
`endif
);

    localparam int unsigned ALIGN_B = DATA_W / 8;

    // Error vector bit positions: {prot, misalign, oor}
    localparam int unsigned ErrOor  = 0;
    localparam int unsigned ErrMis  = 1;
    localparam int unsigned ErrProt = 2;

    // StSetup means "a setup phase was seen last cycle", so the current cycle
    // may be the access phase of that transfer.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    state_e             r_state;
    logic [2:0]         r_err_q;
    logic [2:0]         r_err_status;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_err_irq;

    logic               w_setup;
    logic               w_access;
    logic               w_done;
    logic               w_err_done;
    logic               w_hit;
    logic               w_hit_ro;
    logic               w_misalign;
    logic [2:0]         w_err_vec;
    logic [ADDR_W:0]    w_addr_x;

    assign w_setup  = psel & ~penable;
    assign w_access = psel & penable;

    // Ready only for an access phase that follows a tracked setup phase; after a
    // reset mid-transfer the master has to restart with a fresh setup phase.
    assign w_done     = (r_state == StSetup) & w_access;
    assign w_err_done = w_done & (|r_err_q);

    assign pready  = w_done;
    assign pslverr = w_done & (|r_err_q);

    // Region decode; the extra MSB keeps windows at the top of the space from wrapping
    assign w_addr_x = {1'b0, paddr};

    // Region match; iterating downward lets the lowest matching index win
    always_comb begin
        logic [ADDR_W:0] w_base;
        logic [ADDR_W:0] w_limit;
        w_hit    = 1'b0;
        w_hit_ro = 1'b0;
        w_base   = '0;
        w_limit  = '0;
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            w_base  = {1'b0, REGION_BASE[i*ADDR_W +: ADDR_W]};
            w_limit = w_base + ((ADDR_W + 1)'(1) << REGION_LOG2SZ[i*8 +: 8]);
            if ((w_addr_x >= w_base) && (w_addr_x < w_limit)) begin
                w_hit    = 1'b1;
                w_hit_ro = REGION_RO[i];
            end
        end
    end

    assign w_misalign = (paddr & ADDR_W'(ALIGN_B - 1)) != '0;

    // Assemble the error vector; prot only applies when some region matched
    always_comb begin
        w_err_vec          = '0;
        w_err_vec[ErrOor]  = ~w_hit;
        w_err_vec[ErrMis]  = w_misalign;
        w_err_vec[ErrProt] = w_hit & w_hit_ro & pwrite;
    end

    // Transfer phase tracking and the per-transfer error register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_err_q <= '0;
        end else begin
            if (w_setup) begin
                r_state <= StSetup;
                r_err_q <= w_err_vec;
            end else if (w_done) begin
                r_state <= StAccess;
            end else begin
                r_state <= StIdle;
            end
        end
    end

    // Sticky status and saturating counter; a same-cycle error beats clr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_status <= '0;
            r_err_cnt    <= '0;
        end else if (w_err_done) begin
            if (clr) begin
                r_err_status <= r_err_q;
                r_err_cnt    <= CNT_W'(1);
            end else begin
                r_err_status <= r_err_status | r_err_q;
                if (r_err_cnt != {CNT_W{1'b1}}) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end else if (clr) begin
            r_err_status <= '0;
            r_err_cnt    <= '0;
        end
    end

    // One-cycle interrupt pulse after each errored completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_irq <= 1'b0;
        end else begin
            r_err_irq <= w_err_done;
        end
    end

    assign err_status = r_err_status;
    assign err_cnt    = r_err_cnt;
    assign err_irq    = r_err_irq;

`ifdef APB_ERR_MON_CAPTURE_EN
    logic [ADDR_W-1:0] r_err_addr;
    logic [2:0]        r_err_type;
    logic              r_err_valid;

    // First-error capture; clr re-arms it, and an error in the clr cycle is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_addr  <= '0;
            r_err_type  <= '0;
            r_err_valid <= 1'b0;
        end else if (w_err_done && (clr || !r_err_valid)) begin
            r_err_addr  <= paddr;
            r_err_type  <= r_err_q;
            r_err_valid <= 1'b1;
        end else if (clr) begin
            r_err_addr  <= '0;
            r_err_type  <= '0;
            r_err_valid <= 1'b0;
        end
    end

    assign err_addr  = r_err_addr;
    assign err_type  = r_err_type;
    assign err_valid = r_err_valid;
`endif

endmodule

// File: tb/tb_apb_err_mon.sv
// Directed bench for apb_err_mon with a transfer-level reference model that
// is compared against the DUT on every cycle, plus literal spot checks.
module tb_apb_err_mon;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic        pready;
    logic        pslverr;
    logic        clr;
    logic [2:0]  err_status;
    logic [7:0]  err_cnt;
    logic        err_irq;
`ifdef APB_ERR_MON_CAPTURE_EN
    logic [31:0] err_addr;
    logic [2:0]  err_type;
    logic        err_valid;
`endif

    always #5 clk = ~clk;

    apb_err_mon dut (
        .clk        (clk),
        .rst        (rst),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pready     (pready),
        .pslverr    (pslverr),
        .clr        (clr),
        .err_status (err_status),
        .err_cnt    (err_cnt),
        .err_irq    (err_irq)
`ifdef APB_ERR_MON_CAPTURE_EN
        ,
        .err_addr   (err_addr),
        .err_type   (err_type),
        .err_valid  (err_valid)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endfunction

    // Reference: region table of the default configuration, in plain arithmetic
    longint unsigned reg_base [2] = '{64'h0, 64'h0010_0000};
    longint unsigned reg_size [2] = '{64'h1_0000, 64'h1000};
    bit              reg_ro   [2] = '{1'b0, 1'b1};

    function automatic logic [2:0] model_err(longint unsigned a, bit w);
        bit hit = 1'b0;
        bit ro  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!hit && a >= reg_base[i] && a < reg_base[i] + reg_size[i]) begin
                hit = 1'b1;
                ro  = reg_ro[i];
            end
        end
        return {hit && ro && w, (a % 8) != 0, !hit};
    endfunction

    // Model state: was last cycle a setup phase, error of pending transfer, counters
    bit         m_setup;
    logic [2:0] m_err;
    logic [2:0] m_status;
    int         m_cnt;
    bit         m_irq;
    bit         cmp_en = 1'b0;

    wire m_done     = m_setup && psel && penable;
    wire m_err_done = m_done && (m_err != 3'b000);

    always @(posedge clk) begin
        if (rst) begin
            m_setup  <= 1'b0;
            m_err    <= 3'b000;
            m_status <= 3'b000;
            m_cnt    <= 0;
            m_irq    <= 1'b0;
        end else begin
            m_irq <= m_err_done;
            if (m_err_done) begin
                m_status <= clr ? m_err : (m_status | m_err);
                m_cnt    <= clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
            end else if (clr) begin
                m_status <= 3'b000;
                m_cnt    <= 0;
            end
            m_setup <= psel && !penable;
            if (psel && !penable) m_err <= model_err(longint'(paddr), pwrite);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_pready",  pready,     m_done);
            chk("cyc_pslverr", pslverr,    m_err_done);
            chk("cyc_status",  err_status, m_status);
            chk("cyc_cnt",     err_cnt,    m_cnt);
            chk("cyc_irq",     err_irq,    m_irq);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completion edge
    // with psel/penable still high so a following call runs back-to-back.
    task automatic xfer(input logic [31:0] a, input bit w, input bit c,
                        output bit rdy, output bit serr);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; clr = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; clr = c;
        @(negedge clk);
        rdy  = pready;
        serr = pslverr;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0; clr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        psel = 1'b0; penable = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit rdy, serr;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_pready",  pready,     1'b0);
        chk("rst_pslverr", pslverr,    1'b0);
        chk("rst_status",  err_status, 3'b000);
        chk("rst_cnt",     err_cnt,    8'd0);
        chk("rst_irq",     err_irq,    1'b0);
`ifdef APB_ERR_MON_CAPTURE_EN
        chk("rst_cap_valid", err_valid, 1'b0);
`endif
        idle(1);

        // Clean read in region 0
        xfer(32'h0000_0008, 1'b0, 1'b0, rdy, serr);
        chk("rd8_pready",  rdy,  1'b1);
        chk("rd8_pslverr", serr, 1'b0);
        idle(1);
        chk("rd8_cnt", err_cnt, 8'd0);

        // Read in the gap between regions
        xfer(32'h0002_0000, 1'b0, 1'b0, rdy, serr);
        chk("gap_pslverr", serr,       1'b1);
        chk("gap_status",  err_status, 3'b001);
        chk("gap_cnt",     err_cnt,    8'd1);
        chk("gap_irq",     err_irq,    1'b1);
        idle(1);
        chk("gap_irq_end", err_irq, 1'b0);

        // Misaligned write into the read-only region
        do_clr();
        chk("clr_status", err_status, 3'b000);
        xfer(32'h0010_0004, 1'b1, 1'b0, rdy, serr);
        chk("ro_pslverr", serr,       1'b1);
        chk("ro_status",  err_status, 3'b110);
`ifdef APB_ERR_MON_CAPTURE_EN
        chk("ro_cap_addr",  err_addr,  32'h0010_0004);
        chk("ro_cap_type",  err_type,  3'b110);
        chk("ro_cap_valid", err_valid, 1'b1);
`endif
        idle(1);

        // Region 1 boundary
        xfer(32'h0010_0FF8, 1'b0, 1'b0, rdy, serr);
        chk("end_in_pslverr", serr, 1'b0);
        xfer(32'h0010_1000, 1'b0, 1'b0, rdy, serr);
        chk("end_out_pslverr", serr, 1'b1);
        chk("end_out_status",  err_status, 3'b111);
`ifdef APB_ERR_MON_CAPTURE_EN
        chk("cap_kept_addr", err_addr, 32'h0010_0004);
`endif
        idle(1);

        // Counter saturation with back-to-back oor reads
        do_clr();
        for (int i = 0; i < 300; i++) xfer(32'h0003_0000, 1'b0, 1'b0, rdy, serr);
        chk("sat_cnt", err_cnt, 8'd255);
        xfer(32'h0003_0000, 1'b0, 1'b1, rdy, serr);
        chk("clr_err_cnt",    err_cnt,    8'd1);
        chk("clr_err_status", err_status, 3'b001);
`ifdef APB_ERR_MON_CAPTURE_EN
        chk("clr_err_cap", err_addr, 32'h0003_0000);
`endif
        idle(2);

        // Reset asserted during an access phase
        psel = 1'b1; penable = 1'b0; paddr = 32'h0003_0000; pwrite = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_pready",  pready,     1'b0);
        chk("mid_rst_pslverr", pslverr,    1'b0);
        chk("mid_rst_status",  err_status, 3'b000);
        chk("mid_rst_cnt",     err_cnt,    8'd0);
        chk("mid_rst_irq",     err_irq,    1'b0);
        rst = 1'b0;
        idle(1);
        xfer(32'h0002_0000, 1'b0, 1'b0, rdy, serr);
        chk("post_rst_pready",  rdy,     1'b1);
        chk("post_rst_pslverr", serr,    1'b1);
        chk("post_rst_cnt",     err_cnt, 8'd1);
        idle(2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
